// File: rtl/noc_inject_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | noc_inject_arbiter_pkg: arbiter state encodings and flit field helpers.     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_ID_Width
`define Noc_ID_Width 8
`endif

package noc_inject_arbiter_pkg;

  localparam int FLIT_W = `Noc_Data_Width;
  localparam int ID_W   = `Noc_ID_Width;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Header flits carry the source ID in the top field and the destination ID below it.
  function automatic logic [ID_W-1:0] flit_src_id(input logic [FLIT_W-1:0] flit);
    return flit[FLIT_W-1 -: ID_W];
  endfunction

  function automatic logic [ID_W-1:0] flit_dst_id(input logic [FLIT_W-1:0] flit);
    return flit[FLIT_W-ID_W-1 -: ID_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/noc_inject_arbiter_rr_pick.sv
// +----------------------------------------------------------------------------+
// | noc_rr_pick: combinational round-robin picker, first eligible from ptr.    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module noc_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_eligible,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_found
);

  logic [IDX_W-1:0] w_idx;

  // Scan from the farthest offset back to rr_ptr so the closest eligible index wins last.
  always_comb begin
    o_found  = 1'b0;
    o_winner = '0;
    w_idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = IDX_W'((int'(i_rr_ptr) + k) % NUM_REQ);
      if (i_eligible[w_idx]) begin
        o_found  = 1'b1;
        o_winner = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/noc_inject_arbiter.sv
// +----------------------------------------------------------------------------+
// | noc_inject_arbiter: packet-locked round-robin arbiter for router injection.|
// | Optional watchdog: define NOC_INJECT_ARB_TIMEOUT_EN.   Rev 1.0             |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_inject_arbiter
  import noc_inject_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 256,
  parameter int IDX_W       = 2
) (
  input  logic                              noc_clk,
  input  logic                              noc_rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*`Noc_Data_Width-1:0] req_flit,
  input  logic [NUM_REQ-1:0]                req_is_header,
  input  logic [NUM_REQ-1:0]                req_is_tail,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [`Noc_Data_Width-1:0]        out_flit,
  output logic                              out_is_header,
  output logic                              out_is_tail,
  output logic [IDX_W-1:0]                  grant_id,
  output logic                              busy,
  output logic                              err_timeout
);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [IDX_W-1:0]    r_grant_id;
  logic [IDX_W-1:0]    w_grant_nxt;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    w_rr_nxt;
  logic [IDX_W-1:0]    w_grant_inc;
  logic [NUM_REQ-1:0]  w_eligible;
  logic [IDX_W-1:0]    w_pick;
  logic                w_found;
  logic                w_xfer;
  logic                w_timeout;
  logic [FLIT_W-1:0]   w_flit_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_flit_arr[gi] = req_flit[gi*FLIT_W +: FLIT_W];
  end

  assign w_eligible = req_valid & req_is_header;

  noc_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_eligible (w_eligible),
    .i_rr_ptr   (r_rr_ptr),
    .o_winner   (w_pick),
    .o_found    (w_found)
  );

  assign w_grant_inc = (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
  assign w_xfer      = (r_state == ARB_LOCKED) & req_valid[r_grant_id] & out_ready;

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_state    <= ARB_IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant_id <= w_grant_nxt;
      r_rr_ptr   <= w_rr_nxt;
    end
  end

  // IDLE never forwards anything, which costs one bubble cycle per packet.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant_id;
    w_rr_nxt      = r_rr_ptr;
    req_ready     = '0;
    out_valid     = 1'b0;
    out_flit      = '0;
    out_is_header = 1'b0;
    out_is_tail   = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_pick;
          w_state_nxt = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        out_valid             = req_valid[r_grant_id];
        out_flit              = w_flit_arr[r_grant_id];
        out_is_header         = req_is_header[r_grant_id];
        out_is_tail           = req_is_tail[r_grant_id];
        req_ready[r_grant_id] = out_ready;
        if ((w_xfer && req_is_tail[r_grant_id]) || w_timeout) begin
          w_state_nxt = ARB_IDLE;
          w_rr_nxt    = w_grant_inc;
        end
      end
    endcase
  end

  assign grant_id = r_grant_id;
  assign busy     = (r_state == ARB_LOCKED);

`ifdef NOC_INJECT_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

  logic [STALL_W-1:0] r_stall_cnt;
  logic               r_err_timeout;

  // Fires on the TIMEOUT_CYC-th consecutive stalled LOCKED cycle.
  assign w_timeout = (r_state == ARB_LOCKED) && !w_xfer &&
                     (r_stall_cnt == STALL_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_stall_cnt   <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if ((r_state != ARB_LOCKED) || w_xfer || w_timeout) begin
        r_stall_cnt <= '0;
      end else begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
`ifndef SYNTHESIS
        $display("noc_inject_arbiter: watchdog timeout, grant %0d force-released", r_grant_id);
`endif
      end
    end
  end

  assign err_timeout = r_err_timeout;
`else
  logic w_unused_timeout_cfg;

  // Watchdog limit has no effect when the watchdog is not built.
  assign w_unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign w_timeout            = 1'b0;
  assign err_timeout          = 1'b0;
`endif

endmodule

`default_nettype wire
